// File: rtl/volume_sched_pkg.sv
// Shared types and default constants for the volume sample scheduler.
package volume_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RELEASE   = 3'd5
  } sched_state_t;

  typedef logic ch_id_t;

  localparam int DEFAULT_START_HOLD     = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: on contention the channel not granted last wins.
module rr_arbiter2
  import volume_sched_pkg::*;
(
  input  logic [1:0] i_req,
  input  ch_id_t     i_last_grant,
  output ch_id_t     o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = 1'b0;
    case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/volume_sample_scheduler.sv
// Dispatches channel samples to a volume engine through a start/finish handshake.
// Optional engine watchdog enabled by defining VOL_SCHED_TIMEOUT_EN.
module volume_sample_scheduler
  import volume_sched_pkg::*;
#(
  parameter int START_HOLD     = DEFAULT_START_HOLD,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] sample0,
  input  logic [7:0] sample1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] vol_sample,
  output logic       vol_start,
  input  logic       vol_finish,
  output logic       active_ch,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

  sched_state_t r_state;
  sched_state_t w_state_next;
  logic [3:0]   r_hold_cnt;
  ch_id_t       r_win;
  ch_id_t       r_last_grant;
  ch_id_t       r_active_ch;
  ch_id_t       w_arb_id;
  logic         w_arb_valid;
  logic         w_timeout;
  logic [7:0]   r_vol_sample;
  logic         r_vol_start;
  logic         r_ack0;
  logic         r_ack1;
  logic         r_busy;

  rr_arbiter2 u_arb (
    .i_req        ({req1, req0}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_id),
    .o_valid      (w_arb_valid)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_arb_valid && vol_finish) w_state_next = ST_GRANT;
      ST_GRANT:     w_state_next = ST_START;
      ST_START:     if (r_hold_cnt == HOLD_LAST) w_state_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!vol_finish) w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (vol_finish) w_state_next = ST_RELEASE;
      ST_RELEASE:   w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
    // A watchdog expiry abandons the handshake and still acknowledges the requester.
    if (w_timeout) w_state_next = ST_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= 4'd0;
      r_win        <= 1'b0;
      r_last_grant <= 1'b1;
      r_active_ch  <= 1'b0;
      r_vol_sample <= 8'd0;
      r_vol_start  <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_vol_start <= (w_state_next == ST_START);
      r_hold_cnt  <= (r_state == ST_START && w_state_next == ST_START) ? r_hold_cnt + 4'd1 : 4'd0;
      r_ack0      <= (w_state_next == ST_RELEASE || w_timeout) && (r_active_ch == 1'b0);
      r_ack1      <= (w_state_next == ST_RELEASE || w_timeout) && (r_active_ch == 1'b1);
      if (r_state == ST_IDLE && w_state_next == ST_GRANT) r_win <= w_arb_id;
      if (r_state == ST_GRANT) begin
        r_vol_sample <= r_win ? sample1 : sample0;
        r_active_ch  <= r_win;
        r_last_grant <= r_win;
      end
    end
  end

`ifdef VOL_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  logic            w_in_wait;

  assign w_in_wait = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE);
  assign w_timeout = w_in_wait && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wd_cnt <= (w_in_wait && !w_timeout) ? r_wd_cnt + 1'b1 : '0;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign vol_sample = r_vol_sample;
  assign vol_start  = r_vol_start;
  assign active_ch  = r_active_ch;
  assign busy       = r_busy;

endmodule
